// File: rtl/prim_fifo_rr_wr_ctrl_pkg.sv
// Shared helpers for the round-robin FIFO write controller.
// Holds the priority-rotation helper that the arbiter uses.
package prim_fifo_rr_wr_ctrl_pkg;

    // Index that follows idx in a ring of n requesters.
    function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/prim_fifo_sync_cnt.sv
// FIFO read/write pointer pair with a wrap-phase MSB and arbitrary depth.
// With Secure=1 a shadow copy of each pointer runs alongside and any disagreement raises err_o.
module prim_fifo_sync_cnt #(
    parameter int Width  = 3,
    parameter int Depth  = 4,
    parameter bit Secure = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             incr_wptr_i,
    input  logic             incr_rptr_i,
    output logic [Width-1:0] wptr_o,
    output logic [Width-1:0] rptr_o,
    output logic             err_o
);

    localparam int LowW = Width - 1;

    // Low bits count 0..Depth-1; leaving Depth-1 clears them and flips the phase bit.
    function automatic logic [Width-1:0] ptr_incr(logic [Width-1:0] p);
        logic [Width-1:0] n;
        if (p[LowW-1:0] == LowW'(Depth - 1)) begin
            n = {~p[Width-1], {LowW{1'b0}}};
        end else begin
            n = {p[Width-1], p[LowW-1:0] + 1'b1};
        end
        return n;
    endfunction

    logic [Width-1:0] wptr_q;
    logic [Width-1:0] rptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (incr_wptr_i) begin
                wptr_q <= ptr_incr(wptr_q);
            end
            if (incr_rptr_i) begin
                rptr_q <= ptr_incr(rptr_q);
            end
        end
    end

    assign wptr_o = wptr_q;
    assign rptr_o = rptr_q;

    if (Secure) begin : g_secure
        logic [Width-1:0] wptr_shadow_q;
        logic [Width-1:0] rptr_shadow_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr_shadow_q <= '0;
                rptr_shadow_q <= '0;
            end else if (clr_i) begin
                wptr_shadow_q <= '0;
                rptr_shadow_q <= '0;
            end else begin
                if (incr_wptr_i) begin
                    wptr_shadow_q <= ptr_incr(wptr_shadow_q);
                end
                if (incr_rptr_i) begin
                    rptr_shadow_q <= ptr_incr(rptr_shadow_q);
                end
            end
        end

        assign err_o = (wptr_shadow_q != wptr_q) || (rptr_shadow_q != rptr_q);
    end else begin : g_plain
        assign err_o = 1'b0;
    end

endmodule

// File: rtl/prim_fifo_rr_wr_ctrl.sv
// Multi-writer synchronous FIFO: a round-robin arbiter admits one writer per cycle,
// entries carry the writer index, and a single valid/ready port drains the head.
module prim_fifo_rr_wr_ctrl
    import prim_fifo_rr_wr_ctrl_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int Depth     = 4,
    parameter int DataWidth = 32,
    parameter bit Secure    = 1'b0,
    localparam int PtrW     = $clog2(Depth) + 1,
    localparam int IdW      = $clog2(NumReq),
    localparam int DepthW   = $clog2(Depth + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic [NumReq-1:0]           req_valid_i,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic                        rd_valid_o,
    input  logic                        rd_ready_i,
    output logic [DataWidth-1:0]        rd_data_o,
    output logic [IdW-1:0]              rd_src_o,
    output logic [DepthW-1:0]           depth_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic                        err_o
);

    localparam int LowW = PtrW - 1;

    logic [PtrW-1:0]      wptr;
    logic [PtrW-1:0]      rptr;
    logic [LowW-1:0]      wlow;
    logic [LowW-1:0]      rlow;
    logic [PtrW-1:0]      depth_calc;
    logic                 flush;
    logic                 full;
    logic                 empty;
    logic [NumReq-1:0]    eligible;
    logic [IdW-1:0]       prio_q;
    logic                 grant_vld;
    logic [IdW-1:0]       grant_idx;
    logic [DataWidth-1:0] wdata;
    logic                 push;
    logic                 pop;
    logic                 cnt_err;

    logic [DataWidth-1:0] mem_data [Depth];
    logic [IdW-1:0]       mem_src  [Depth];

    assign flush = rst_i | clr_i;
    assign wlow  = wptr[LowW-1:0];
    assign rlow  = rptr[LowW-1:0];

    // Status comes from the registered pointers only, so ready never depends on ready.
    assign full  = (wlow == rlow) && (wptr[PtrW-1] != rptr[PtrW-1]);
    assign empty = (wptr == rptr);

    always_comb begin
        depth_calc = '0;
        if (wptr[PtrW-1] == rptr[PtrW-1]) begin
            depth_calc = {1'b0, wlow} - {1'b0, rlow};
        end else begin
            depth_calc = PtrW'(Depth) - {1'b0, rlow} + {1'b0, wlow};
        end
    end

    assign depth_o    = DepthW'(depth_calc);
    assign full_o     = full;
    assign empty_o    = empty;
    assign rd_valid_o = !empty;

    assign eligible = req_valid_i & {NumReq{!full && !flush}};

    // Lowest eligible index at or above prio wins; otherwise lowest index below prio.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int j = 0; j < NumReq; j++) begin
            if (!grant_vld && eligible[j] && (j >= int'(prio_q))) begin
                grant_vld = 1'b1;
                grant_idx = IdW'(j);
            end
        end
        for (int j = 0; j < NumReq; j++) begin
            if (!grant_vld && eligible[j] && (j < int'(prio_q))) begin
                grant_vld = 1'b1;
                grant_idx = IdW'(j);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        wdata       = '0;
        for (int j = 0; j < NumReq; j++) begin
            if (grant_vld && (grant_idx == IdW'(j))) begin
                req_ready_o[j] = 1'b1;
                wdata          = req_data_i[j*DataWidth +: DataWidth];
            end
        end
    end

    assign push = grant_vld;
    assign pop  = !empty && rd_ready_i && !flush;

    always_ff @(posedge clk_i) begin
        if (flush) begin
            prio_q <= '0;
        end else if (grant_vld) begin
            prio_q <= IdW'(rr_next(32'(grant_idx), NumReq));
        end
    end

    // Storage is never reset; only the pointers decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wlow] <= wdata;
            mem_src[wlow]  <= grant_idx;
        end
    end

    assign rd_data_o = mem_data[rlow];
    assign rd_src_o  = mem_src[rlow];

    prim_fifo_sync_cnt #(
        .Width  (PtrW),
        .Depth  (Depth),
        .Secure (Secure)
    ) u_cnt (
        .clk_i       (clk_i),
        .rst_ni      (1'b1),
        .clr_i       (flush),
        .incr_wptr_i (push),
        .incr_rptr_i (pop),
        .wptr_o      (wptr),
        .rptr_o      (rptr),
        .err_o       (cnt_err)
    );

    assign err_o = cnt_err;

    a_ready_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_ready_o));
    a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i) !(full_o && |req_ready_o));
    a_depth_bound  : assert property (@(posedge clk_i) disable iff (rst_i) depth_o <= DepthW'(Depth));
    a_no_overtake  : assert property (@(posedge clk_i) disable iff (rst_i) !(pop && empty));

endmodule

// File: tb/tb_prim_fifo_rr_wr_ctrl.sv
// Bench for prim_fifo_rr_wr_ctrl: a queue-based FIFO model with a ring-priority arbiter
// checks a 4x4x32 instance; a 3-deep 8-bit instance covers the non-power-of-2 case.
module tb_prim_fifo_rr_wr_ctrl;

    localparam int NR = 4;
    localparam int D  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic            rst = 1'b1;
    logic            clr = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            rd_valid;
    logic            rd_ready = 1'b0;
    logic [DW-1:0]   rd_data;
    logic [1:0]      rd_src;
    logic [2:0]      depth;
    logic            full;
    logic            empty;
    logic            err;

    // small instance
    logic            s_rst = 1'b1;
    logic            s_clr = 1'b0;
    logic [3:0]      s_valid = '0;
    logic [31:0]     s_data = '0;
    logic [3:0]      s_ready;
    logic            s_rd_valid;
    logic            s_rd_ready = 1'b0;
    logic [7:0]      s_rd_data;
    logic [1:0]      s_rd_src;
    logic [1:0]      s_depth;
    logic            s_full;
    logic            s_empty;
    logic            s_err;

    prim_fifo_rr_wr_ctrl #(.NumReq(NR), .Depth(D), .DataWidth(DW), .Secure(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_src_o(rd_src),
        .depth_o(depth), .full_o(full), .empty_o(empty), .err_o(err)
    );

    prim_fifo_rr_wr_ctrl #(.NumReq(4), .Depth(3), .DataWidth(8), .Secure(1'b1)) dut_s (
        .clk_i(clk), .rst_i(s_rst), .clr_i(s_clr),
        .req_valid_i(s_valid), .req_data_i(s_data), .req_ready_o(s_ready),
        .rd_valid_o(s_rd_valid), .rd_ready_i(s_rd_ready), .rd_data_o(s_rd_data), .rd_src_o(s_rd_src),
        .depth_o(s_depth), .full_o(s_full), .empty_o(s_empty), .err_o(s_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: queue of {src, data}, ring priority pointer
    logic [DW+1:0] exp_q[$];
    int            m_prio = 0;
    int            e_grant;
    logic [NR-1:0] e_ready;

    task automatic drive(input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                         input logic rr, input logic c, input logic r);
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        rd_ready  = rr;
        clr       = c;
        rst       = r;
        e_grant   = -1;
        if (!r && !c && exp_q.size() < D) begin
            for (int k = 0; k < NR; k++) begin
                if (e_grant < 0 && v[(m_prio + k) % NR]) e_grant = (m_prio + k) % NR;
            end
        end
        e_ready = (e_grant >= 0) ? NR'(1 << e_grant) : '0;
        #1;
    endtask

    task automatic commit();
        @(posedge clk);
        if (rst || clr) begin
            exp_q.delete();
            m_prio = 0;
        end else begin
            if (exp_q.size() > 0 && rd_ready) void'(exp_q.pop_front());
            if (e_grant >= 0) begin
                exp_q.push_back({2'(e_grant), req_data[e_grant*DW +: DW]});
                m_prio = (e_grant + 1) % NR;
            end
        end
    endtask

    function automatic logic [NR*DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive('1, rand_data(), 1'b1, 1'b0, 1'b1);
            n_cmp++;
            if (req_ready !== '0) begin
                n_bad++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
            end
            commit();
        end
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (empty !== 1'b1 || depth !== 3'd0 || full !== 1'b0 || rd_valid !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_status: empty=%b depth=%0d full=%b rd_valid=%b err=%b expected 1 0 0 0 0",
                     empty, depth, full, rd_valid, err);
        end
        commit();
    endtask

    task automatic test_fairness();
        drive('0, '0, 1'b0, 1'b1, 1'b0);
        commit();
        for (int i = 0; i < 12; i++) begin
            drive('1, rand_data(), 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (req_ready !== NR'(1 << (i % NR)) || req_ready !== e_ready) begin
                n_bad++; $display("FAIL fair_grant: cycle %0d got %b expected %b", i, req_ready, NR'(1 << (i % NR)));
            end
            if (i > 0) begin
                n_cmp++;
                if (rd_valid !== 1'b1 || rd_src !== 2'((i - 1) % NR) || rd_data !== exp_q[0][DW-1:0]) begin
                    n_bad++;
                    $display("FAIL fair_head: cycle %0d valid=%b src=%0d data=%h expected 1 %0d %h",
                             i, rd_valid, rd_src, rd_data, (i - 1) % NR, exp_q[0][DW-1:0]);
                end
            end
            commit();
        end
    endtask

    task automatic test_fill_full();
        logic [DW-1:0] first;
        drive('0, '0, 1'b0, 1'b1, 1'b0);
        commit();
        first = '0;
        for (int i = 0; i < D; i++) begin
            drive(4'b0100, rand_data(), 1'b0, 1'b0, 1'b0);
            if (i == 0) first = req_data[2*DW +: DW];
            n_cmp++;
            if (req_ready !== 4'b0100) begin
                n_bad++; $display("FAIL fill_ready: write %0d got %b expected 0100", i, req_ready);
            end
            commit();
        end
        drive(4'b0100, rand_data(), 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (full !== 1'b1 || depth !== 3'd4 || req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL full_status: full=%b depth=%0d ready=%b expected 1 4 0000", full, depth, req_ready);
        end
        commit();
        drive(4'b0100, rand_data(), 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (req_ready !== 4'b0000 || rd_data !== first || rd_src !== 2'd2) begin
            n_bad++; $display("FAIL full_pop_same: ready=%b data=%h src=%0d expected 0000 %h 2", req_ready, rd_data, rd_src, first);
        end
        commit();
        drive(4'b0100, rand_data(), 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (req_ready !== 4'b0100 || depth !== 3'd3 || full !== 1'b0) begin
            n_bad++; $display("FAIL full_pop_next: ready=%b depth=%0d full=%b expected 0100 3 0", req_ready, depth, full);
        end
        commit();
    endtask

    task automatic test_wrap();
        drive('0, '0, 1'b0, 1'b1, 1'b0);
        commit();
        drive(4'b0010, rand_data(), 1'b0, 1'b0, 1'b0);
        commit();
        for (int i = 0; i < 10; i++) begin
            drive(NR'($urandom_range(1, 15)), rand_data(), 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (depth !== 3'd1 || req_ready !== e_ready || rd_data !== exp_q[0][DW-1:0] || rd_src !== exp_q[0][DW+1:DW]) begin
                n_bad++;
                $display("FAIL wrap: pair %0d depth=%0d ready=%b data=%h src=%0d expected 1 %b %h %0d",
                         i, depth, req_ready, rd_data, rd_src, e_ready, exp_q[0][DW-1:0], exp_q[0][DW+1:DW]);
            end
            commit();
        end
    endtask

    task automatic test_clear();
        drive('0, '0, 1'b0, 1'b1, 1'b0);
        commit();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, rand_data(), 1'b0, 1'b0, 1'b0);
            commit();
        end
        drive('1, rand_data(), 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (depth !== 3'd3 || req_ready !== 4'b0000) begin
            n_bad++; $display("FAIL clear_pre: depth=%0d ready=%b expected 3 0000", depth, req_ready);
        end
        commit();
        drive('1, rand_data(), 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (depth !== 3'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL clear_post: depth=%0d empty=%b rd_valid=%b ready=%b expected 0 1 0 0001",
                     depth, empty, rd_valid, req_ready);
        end
        commit();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(NR'($urandom_range(0, 15)), rand_data(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0), 1'b0);
            n_cmp++;
            if (req_ready !== e_ready || depth !== 3'(exp_q.size()) || full !== (exp_q.size() == D) ||
                empty !== (exp_q.size() == 0) || err !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_status: cycle %0d ready=%b depth=%0d full=%b empty=%b err=%b expected %b %0d",
                         i, req_ready, depth, full, empty, err, e_ready, exp_q.size());
            end
            if (exp_q.size() > 0) begin
                n_cmp++;
                if (rd_valid !== 1'b1 || rd_data !== exp_q[0][DW-1:0] || rd_src !== exp_q[0][DW+1:DW]) begin
                    n_bad++;
                    $display("FAIL rand_head: cycle %0d valid=%b data=%h src=%0d expected 1 %h %0d",
                             i, rd_valid, rd_data, rd_src, exp_q[0][DW-1:0], exp_q[0][DW+1:DW]);
                end
            end
            commit();
        end
    endtask

    task automatic test_non_pow2();
        logic [7:0] pay [4];
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3; pay[3] = 8'hD4;
        @(negedge clk); s_rst = 1'b1; s_valid = '0; s_rd_ready = 1'b0;
        @(negedge clk); s_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 4'b0001; s_data = {24'h0, pay[i]}; s_rd_ready = 1'b0;
            #1;
            n_cmp++;
            if (s_ready !== 4'b0001 || s_depth !== 2'(i)) begin
                n_bad++; $display("FAIL np2_fill: write %0d ready=%b depth=%0d expected 0001 %0d", i, s_ready, s_depth, i);
            end
            @(negedge clk);
        end
        s_data = {24'h0, pay[3]};
        #1;
        n_cmp++;
        if (s_full !== 1'b1 || s_depth !== 2'd3 || s_ready !== 4'b0000 || s_err !== 1'b0) begin
            n_bad++; $display("FAIL np2_full: full=%b depth=%0d ready=%b err=%b expected 1 3 0000 0", s_full, s_depth, s_ready, s_err);
        end
        @(negedge clk);
        s_rd_ready = 1'b1;
        #1;
        n_cmp++;
        if (s_ready !== 4'b0000 || s_rd_data !== pay[0]) begin
            n_bad++; $display("FAIL np2_pop_same: ready=%b data=%h expected 0000 %h", s_ready, s_rd_data, pay[0]);
        end
        @(negedge clk);
        s_rd_ready = 1'b0;
        #1;
        n_cmp++;
        if (s_ready !== 4'b0001 || s_depth !== 2'd2) begin
            n_bad++; $display("FAIL np2_pop_next: ready=%b depth=%0d expected 0001 2", s_ready, s_depth);
        end
        @(negedge clk);
        s_valid = '0; s_rd_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            n_cmp++;
            if (s_rd_valid !== 1'b1 || s_rd_data !== pay[i] || s_rd_src !== 2'd0) begin
                n_bad++; $display("FAIL np2_order: entry %0d valid=%b data=%h src=%0d expected 1 %h 0",
                                  i, s_rd_valid, s_rd_data, s_rd_src, pay[i]);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (s_empty !== 1'b1 || s_depth !== 2'd0) begin
            n_bad++; $display("FAIL np2_drained: empty=%b depth=%0d expected 1 0", s_empty, s_depth);
        end
        s_rd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_fill_full();
        test_wrap();
        test_clear();
        test_random();
        test_non_pow2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
